// File: rtl/amo_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// amo_sequencer_if : valid/ready memory port of the AMO sequencer | Rev 1.0
// ---------------------------------------------------------------------------
interface amo_sequencer_if #(
  parameter int XLEN = 32
);
  logic            mem_valid;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/amo_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// amo_sequencer : RV32A LR/SC/AMO read-modify-write sequencer | Rev 1.0
// ---------------------------------------------------------------------------
`ifndef AMO_OP_WIDTH
`define AMO_OP_WIDTH 4
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 3
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 3'd0
`endif
`ifndef ALU_OP_AMO
`define ALU_OP_AMO 3'd5
`endif
`ifndef AMO_OP_LR_W
`define AMO_OP_LR_W   4'd0
`define AMO_OP_SC_W   4'd1
`define AMO_OP_SWAP_W 4'd2
`endif

module amo_sequencer #(
  parameter int XLEN         = 32,
  parameter int RESV_GRANULE = 2
) (
  input  wire logic                     clk,
  input  wire logic                     resetn,
  input  wire logic                     start,
  input  wire logic [`AMO_OP_WIDTH-1:0] amo_op,
  input  wire logic [XLEN-1:0]          addr,
  input  wire logic [XLEN-1:0]          rs2_data,
  input  wire logic                     resv_clear,
  output logic      [`ALU_OP_WIDTH-1:0] ALUOp,
  output logic      [`AMO_OP_WIDTH-1:0] AMOop,
  output logic      [XLEN-1:0]          alu_a,
  output logic      [XLEN-1:0]          alu_b,
  input  wire logic [XLEN-1:0]          alu_result,
  amo_sequencer_if.master               mem,
  output logic                          busy,
  output logic                          done,
  output logic      [XLEN-1:0]          rd_data,
  output logic                          misaligned
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int GW = XLEN - RESV_GRANULE;

  logic [2:0]               state_q, state_d;
  logic [`AMO_OP_WIDTH-1:0] amoop_q, amoop_d;
  logic [XLEN-1:0]          alu_a_q, alu_a_d;
  logic [XLEN-1:0]          alu_b_q, alu_b_d;
  logic [XLEN-1:0]          addr_q, addr_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic [XLEN-1:0]          rd_data_q, rd_data_d;
  logic                     misaligned_q, misaligned_d;
  logic                     resv_valid_q, resv_valid_d;
  logic [GW-1:0]            resv_addr_q, resv_addr_d;

  logic w_start_misaligned;
  logic w_start_sc;
  logic w_start_match;
  logic w_store_match;

  assign w_start_misaligned = (addr[1:0] != 2'b00);
  assign w_start_sc         = (amo_op == `AMO_OP_SC_W);
  assign w_start_match      = resv_valid_q && (addr[XLEN-1:RESV_GRANULE] == resv_addr_q);
  assign w_store_match      = resv_valid_q && (addr_q[XLEN-1:RESV_GRANULE] == resv_addr_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (w_start_misaligned)  state_d = S_DONE;
          else if (w_start_sc)     state_d = w_start_match ? S_STORE : S_DONE;
          else                     state_d = S_LOAD;
        end
      end
      S_LOAD:  if (mem.mem_ready) state_d = (amoop_q == `AMO_OP_LR_W) ? S_DONE : S_EXEC;
      S_EXEC:  state_d = S_STORE;
      S_STORE: if (mem.mem_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ALUOp          = (state_q == S_EXEC) ? `ALU_OP_AMO : `ALU_OP_ADD;
    mem.mem_valid  = (state_q == S_LOAD) || (state_q == S_STORE);
    mem.mem_we     = (state_q == S_STORE);
    mem.mem_wstrb  = (state_q == S_STORE) ? 4'hF : 4'h0;
    mem.mem_addr   = addr_q;
    mem.mem_wdata  = wdata_q;
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
    AMOop          = amoop_q;
    alu_a          = alu_a_q;
    alu_b          = alu_b_q;
    rd_data        = rd_data_q;
    misaligned     = misaligned_q;
  end

  always_comb begin
    amoop_d      = amoop_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    misaligned_d = misaligned_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          amoop_d      = amo_op;
          alu_b_d      = rs2_data;
          wdata_d      = rs2_data;
          addr_d       = {addr[XLEN-1:2], 2'b00};
          misaligned_d = w_start_misaligned;
          // A failing SC reports 1; a successful one overwrites this with 0 on store.
          rd_data_d    = (w_start_sc && !w_start_misaligned) ? {{(XLEN-1){1'b0}}, 1'b1}
                                                             : '0;
          if (w_start_sc && !w_start_misaligned) resv_valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (mem.mem_ready) begin
          alu_a_d = mem.mem_rdata;
          if (amoop_q == `AMO_OP_LR_W) begin
            rd_data_d    = mem.mem_rdata;
            resv_valid_d = 1'b1;
            resv_addr_d  = addr_q[XLEN-1:RESV_GRANULE];
          end
        end
      end
      S_EXEC: begin
        wdata_d   = (amoop_q == `AMO_OP_SWAP_W) ? alu_b_q : alu_result;
        rd_data_d = alu_a_q;
      end
      S_STORE: begin
        if (mem.mem_ready) begin
          if (amoop_q == `AMO_OP_SC_W) rd_data_d = '0;
          if (w_store_match)           resv_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (resv_clear) resv_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      amoop_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      misaligned_q <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      amoop_q      <= amoop_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      misaligned_q <= misaligned_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amo_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_amo_sequencer : directed bench with memory responder and ALU model | Rev 1.0
// ---------------------------------------------------------------------------
`ifndef AMO_OP_WIDTH
`define AMO_OP_WIDTH 4
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 3
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 3'd0
`endif
`ifndef ALU_OP_AMO
`define ALU_OP_AMO 3'd5
`endif
`ifndef AMO_OP_LR_W
`define AMO_OP_LR_W   4'd0
`define AMO_OP_SC_W   4'd1
`define AMO_OP_SWAP_W 4'd2
`endif

module tb_amo_sequencer;

  localparam logic [3:0] OP_LR   = 4'd0;
  localparam logic [3:0] OP_SC   = 4'd1;
  localparam logic [3:0] OP_SWAP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  amo_op = '0;
  logic [31:0] addr = '0;
  logic [31:0] rs2_data = '0;
  logic        resv_clear = 1'b0;
  logic [2:0]  ALUOp;
  logic [3:0]  AMOop;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        busy, done, misaligned;
  logic [31:0] rd_data;

  amo_sequencer_if #(.XLEN(32)) bus ();

  amo_sequencer #(.XLEN(32), .RESV_GRANULE(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .amo_op(amo_op), .addr(addr),
    .rs2_data(rs2_data), .resv_clear(resv_clear), .ALUOp(ALUOp), .AMOop(AMOop),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .mem(bus),
    .busy(busy), .done(done), .rd_data(rd_data), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference ALU standing in for the datapath
  always_comb begin
    alu_result = alu_a + alu_b;
    case (AMOop)
      OP_SWAP: alu_result = alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_MIN:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
      OP_MAX:  alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      OP_MINU: alu_result = (alu_a < alu_b) ? alu_a : alu_b;
      OP_MAXU: alu_result = (alu_a > alu_b) ? alu_a : alu_b;
      default: alu_result = alu_a + alu_b;
    endcase
  end

  // Memory responder: ready after `delay` wait cycles, driven on the falling edge
  logic [31:0] mem [0:255];
  int          delay = 0;
  int          wait_cnt = 0;
  int          n_loads = 0, n_stores = 0, valid_cycles = 0;
  logic [31:0] last_ld_addr = '0, last_st_addr = '0, last_st_data = '0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;
  logic        hold_we = 1'b0;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      bus.mem_ready = 1'b0;
      wait_cnt = 0;
    end else if (bus.mem_valid && !bus.mem_ready) begin
      valid_cycles++;
      if (wait_cnt == 0) begin
        hold_addr  = bus.mem_addr;
        hold_wdata = bus.mem_wdata;
        hold_we    = bus.mem_we;
      end else begin
        check_eq("hold_addr", bus.mem_addr, hold_addr);
        check_eq("hold_we", {31'd0, bus.mem_we}, {31'd0, hold_we});
        if (hold_we) check_eq("hold_wdata", bus.mem_wdata, hold_wdata);
      end
      if (wait_cnt >= delay) begin
        bus.mem_ready = 1'b1;
        if (bus.mem_we) begin
          mem[bus.mem_addr[9:2]] = bus.mem_wdata;
          n_stores++;
          last_st_addr = bus.mem_addr;
          last_st_data = bus.mem_wdata;
        end else begin
          bus.mem_rdata = mem[bus.mem_addr[9:2]];
          n_loads++;
          last_ld_addr = bus.mem_addr;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      if (bus.mem_valid) valid_cycles++;
      bus.mem_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  // Issue one operation and wait (bounded) for done; results sampled on falling edges
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic mis,
                        output int amo_cyc);
    bit got;
    got = 1'b0;
    lat = 0;
    amo_cyc = 0;
    rd = '0;
    mis = 1'b0;
    @(negedge clk);
    start = 1'b1; amo_op = op; addr = a; rs2_data = d;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (ALUOp == `ALU_OP_AMO) amo_cyc++;
      if (done) begin
        got = 1'b1;
        lat = i;
        rd  = rd_data;
        mis = misaligned;
      end
    end
    if (!got) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  int          lat, amo_cyc, st0, vc0;
  logic [31:0] rd;
  logic        mis;
  bit          found;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_aluop", {29'd0, ALUOp}, {29'd0, `ALU_OP_ADD});
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    check_eq("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check_eq("rst_rd", rd_data, 32'd0);
    resetn = 1'b1;

    // AMOADD.W, zero-wait memory
    mem[32'h100 >> 2] = 32'd5;
    run_op(OP_ADD, 32'h100, 32'd3, lat, rd, mis, amo_cyc);
    check_eq("add_lat", lat, 4);
    check_eq("add_rd", rd, 32'd5);
    check_eq("add_ld_addr", last_ld_addr, 32'h100);
    check_eq("add_st_addr", last_st_addr, 32'h100);
    check_eq("add_st_data", last_st_data, 32'd8);
    check_eq("add_amo_cycles", amo_cyc, 1);
    check_eq("add_mis", {31'd0, mis}, 32'd0);
    check_eq("add_idle", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("add_idle2", {31'd0, busy}, 32'd0);

    // AMOXOR.W and AMOMAXU.W through the reference ALU
    mem[32'h140 >> 2] = 32'hF0F0_0000;
    run_op(OP_XOR, 32'h140, 32'h0FF0_FFFF, lat, rd, mis, amo_cyc);
    check_eq("xor_rd", rd, 32'hF0F0_0000);
    check_eq("xor_st", last_st_data, 32'hFF00_FFFF);
    run_op(OP_MAXU, 32'h140, 32'h0000_0001, lat, rd, mis, amo_cyc);
    check_eq("maxu_st", last_st_data, 32'hFF00_FFFF);

    // LR / SC success / SC replay
    mem[32'h200 >> 2] = 32'h77;
    run_op(OP_LR, 32'h200, 32'd0, lat, rd, mis, amo_cyc);
    check_eq("lr_lat", lat, 2);
    check_eq("lr_rd", rd, 32'h77);
    check_eq("lr_amo_cycles", amo_cyc, 0);
    st0 = n_stores;
    run_op(OP_SC, 32'h200, 32'hDEAD, lat, rd, mis, amo_cyc);
    check_eq("sc_lat", lat, 2);
    check_eq("sc_rd", rd, 32'd0);
    check_eq("sc_st_data", last_st_data, 32'hDEAD);
    check_eq("sc_st_cnt", n_stores - st0, 1);
    vc0 = valid_cycles;
    run_op(OP_SC, 32'h200, 32'hBEEF, lat, rd, mis, amo_cyc);
    check_eq("sc2_lat", lat, 1);
    check_eq("sc2_rd", rd, 32'd1);
    check_eq("sc2_novalid", valid_cycles - vc0, 0);

    // resv_clear between LR and SC
    run_op(OP_LR, 32'h200, 32'd0, lat, rd, mis, amo_cyc);
    @(negedge clk); resv_clear = 1'b1;
    @(negedge clk); resv_clear = 1'b0;
    st0 = n_stores;
    run_op(OP_SC, 32'h200, 32'h1234, lat, rd, mis, amo_cyc);
    check_eq("clr_sc_rd", rd, 32'd1);
    check_eq("clr_sc_nost", n_stores - st0, 0);

    // Granule mismatch
    run_op(OP_LR, 32'h200, 32'd0, lat, rd, mis, amo_cyc);
    st0 = n_stores;
    run_op(OP_SC, 32'h204, 32'h1234, lat, rd, mis, amo_cyc);
    check_eq("gran_sc_rd", rd, 32'd1);
    check_eq("gran_sc_nost", n_stores - st0, 0);

    // AMOSWAP.W with 3 wait cycles per request
    delay = 3;
    mem[32'h180 >> 2] = 32'h11;
    run_op(OP_SWAP, 32'h180, 32'h22, lat, rd, mis, amo_cyc);
    check_eq("swap_lat", lat, 10);
    check_eq("swap_rd", rd, 32'h11);
    check_eq("swap_st", last_st_data, 32'h22);
    check_eq("swap_mem", mem[32'h180 >> 2], 32'h22);
    delay = 0;

    // Misaligned AMOOR.W
    vc0 = valid_cycles;
    run_op(OP_OR, 32'h102, 32'hFF, lat, rd, mis, amo_cyc);
    check_eq("mis_lat", lat, 1);
    check_eq("mis_flag", {31'd0, mis}, 32'd1);
    check_eq("mis_rd", rd, 32'd0);
    check_eq("mis_novalid", valid_cycles - vc0, 0);

    // Asynchronous reset while a store is pending
    run_op(OP_LR, 32'h300, 32'd0, lat, rd, mis, amo_cyc);
    delay = 50;
    @(negedge clk);
    start = 1'b1; amo_op = OP_ADD; addr = 32'h300; rs2_data = 32'd1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.mem_valid && bus.mem_we) found = 1'b1;
    end
    check_eq("rst_store_seen", {31'd0, found}, 32'd1);
    check_eq("rst_store_ready", {31'd0, bus.mem_ready}, 32'd0);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_async_valid", {31'd0, bus.mem_valid}, 32'd0);
    check_eq("rst_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    delay = 0;
    @(negedge clk);
    st0 = n_stores;
    run_op(OP_SC, 32'h300, 32'h55, lat, rd, mis, amo_cyc);
    check_eq("rst_sc_rd", rd, 32'd1);
    check_eq("rst_sc_nost", n_stores - st0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
